// File: rtl/partial_full_adder.sv
// Bit-sliced partial full adder: per-slice sum, generate and propagate, registered once behind a valid.
// Define PFA_GROUP_PG_EN to add registered group generate/propagate outputs (grp_g, grp_p).
module partial_full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p
`ifdef PFA_GROUP_PG_EN
    ,
    output logic             grp_g,
    output logic             grp_p
`endif
);

`ifdef PFA_GROUP_PG_EN
    // Fold from slice 0 upward so the MSB term dominates: g[W-1] | p[W-1]&(g[W-2] | ...)
    function automatic logic group_generate(input logic [WIDTH-1:0] gen,
                                            input logic [WIDTH-1:0] prop);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = gen[i] | (prop[i] & acc);
        end
        return acc;
    endfunction
`endif

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] p_r;

    // Per-slice terms; propagate is the XOR form so that sum = p ^ ci
    always_comb begin
        g_s   = a & b;
        p_s   = a ^ b;
        sum_s = p_s ^ ci;
    end

    // Result register: reset wins, otherwise load on valid and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            g_r         <= {WIDTH{1'b0}};
            p_r         <= {WIDTH{1'b0}};
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r <= sum_s;
                g_r   <= g_s;
                p_r   <= p_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign g         = g_r;
    assign p         = p_r;

`ifdef PFA_GROUP_PG_EN
    logic grp_g_s;
    logic grp_p_s;
    logic grp_g_r;
    logic grp_p_r;

    // Group terms come from the same unregistered slice terms as sum/g/p
    always_comb begin
        grp_g_s = group_generate(g_s, p_s);
        grp_p_s = &p_s;
    end

    // Group register shares the timing and reset of the slice results
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_g_r <= 1'b0;
            grp_p_r <= 1'b0;
        end else if (in_valid) begin
            grp_g_r <= grp_g_s;
            grp_p_r <= grp_p_s;
        end
    end

    assign grp_g = grp_g_r;
    assign grp_p = grp_p_r;
`endif

endmodule

// File: tb/tb_partial_full_adder.sv
// Self-checking bench for partial_full_adder at WIDTH 1, 4 and 8 against an arithmetic reference model.
// Group outputs are exercised when PFA_GROUP_PG_EN is defined.
module tb_partial_full_adder;

    logic clk;
    logic rst;

    logic       v1, ov1;
    logic [0:0] a1, b1, c1, s1, g1, p1;
    logic       v4, ov4;
    logic [3:0] a4, b4, c4, s4, g4, p4;
    logic       v8, ov8;
    logic [7:0] a8, b8, c8, s8, g8, p8;
`ifdef PFA_GROUP_PG_EN
    logic gg1, gp1, gg4, gp4, gg8, gp8;
`endif

    int checks = 0;
    int errors = 0;

    partial_full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .ci(c1),
        .out_valid(ov1), .sum(s1), .g(g1), .p(p1)
`ifdef PFA_GROUP_PG_EN
        , .grp_g(gg1), .grp_p(gp1)
`endif
    );
    partial_full_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .ci(c4),
        .out_valid(ov4), .sum(s4), .g(g4), .p(p4)
`ifdef PFA_GROUP_PG_EN
        , .grp_g(gg4), .grp_p(gp4)
`endif
    );
    partial_full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .ci(c8),
        .out_valid(ov8), .sum(s8), .g(g8), .p(p8)
`ifdef PFA_GROUP_PG_EN
        , .grp_g(gg8), .grp_p(gp8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: each slice is a one-bit integer addition a+b(+ci)
    function automatic void pfa_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] ci, output logic [31:0] s,
                                      output logic [31:0] gen, output logic [31:0] prop);
        s = 32'd0; gen = 32'd0; prop = 32'd0;
        for (int i = 0; i < w; i++) begin
            int ta, tb, tc;
            ta = int'(a[i]); tb = int'(b[i]); tc = int'(ci[i]);
            s[i]    = ((ta + tb + tc) % 2) == 1;
            gen[i]  = (ta + tb) == 2;
            prop[i] = (ta + tb) == 1;
        end
    endfunction

    // Group generate is the carry out of a W-bit add with no carry in; group propagate means every slice sums to 1
    function automatic void group_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        output logic gg, output logic gp);
        longint unsigned mask, total;
        mask  = (64'd1 << w) - 64'd1;
        total = (longint'(a) & mask) + (longint'(b) & mask);
        gg = ((total >> w) & 64'd1) == 64'd1;
        gp = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (int'(a[i]) + int'(b[i]) != 1) gp = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] es, eg, ep;
    logic [31:0] h4s, h4g, h4p, h8s, h8g, h8p;
    logic        egg, egp;
    logic        ev8;

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v4 = 1'b0; a4 = 4'd0; b4 = 4'd0; c4 = 4'd0;
        v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 8'd0;
        tick();
        tick();
        check_value("rst_ov4", 32'(ov4), 32'd0);
        check_value("rst_sum4", 32'(s4), 32'd0);
        check_value("rst_g8", 32'(g8), 32'd0);
        check_value("rst_p1", 32'(p1), 32'd0);
        rst = 1'b0;

        // Single slice, every input combination
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv = 3'(k);
            v1 = 1'b1; a1 = kv[2]; b1 = kv[1]; c1 = kv[0];
            tick();
            pfa_model(1, 32'(a1), 32'(b1), 32'(c1), es, eg, ep);
            check_value("w1_ov", 32'(ov1), 32'd1);
            check_value("w1_sum", 32'(s1), es);
            check_value("w1_g", 32'(g1), eg);
            check_value("w1_p", 32'(p1), ep);
        end
        check_value("w1_111_sum", 32'(s1), 32'd1);
        check_value("w1_111_g", 32'(g1), 32'd1);
        check_value("w1_111_p", 32'(p1), 32'd0);
        v1 = 1'b0;

        // Directed WIDTH=4 vector
        v4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110; c4 = 4'b0011;
        tick();
        check_value("w4_ov", 32'(ov4), 32'd1);
        check_value("w4_sum", 32'(s4), 32'h0000_000f);
        check_value("w4_g", 32'(g4), 32'h0000_0002);
        check_value("w4_p", 32'(p4), 32'h0000_000c);

        // Hold: random inputs with in_valid low must not disturb the outputs
        v4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
            tick();
            check_value("hold_ov", 32'(ov4), 32'd0);
            check_value("hold_sum", 32'(s4), 32'h0000_000f);
            check_value("hold_g", 32'(g4), 32'h0000_0002);
            check_value("hold_p", 32'(p4), 32'h0000_000c);
        end

        // Reset overrides a concurrent valid input
        rst = 1'b1; v4 = 1'b1; a4 = 4'hf; b4 = 4'hf; c4 = 4'hf;
        tick();
        check_value("rstv_ov", 32'(ov4), 32'd0);
        check_value("rstv_sum", 32'(s4), 32'd0);
        check_value("rstv_g", 32'(g4), 32'd0);
        check_value("rstv_p", 32'(p4), 32'd0);
        rst = 1'b0; v4 = 1'b0;
        tick();
        check_value("post_rst_ov", 32'(ov4), 32'd0);
        check_value("post_rst_g", 32'(g4), 32'd0);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        check_value("first_ov", 32'(ov4), 32'd1);
        check_value("first_g", 32'(g4), 32'h0000_000f);
        check_value("first_sum", 32'(s4), 32'h0000_000f);
        check_value("first_p", 32'(p4), 32'd0);

`ifdef PFA_GROUP_PG_EN
        v4 = 1'b1; c4 = 4'd0;
        a4 = 4'b0101; b4 = 4'b1010;
        tick();
        check_value("grp1_p", 32'(gp4), 32'd1);
        check_value("grp1_g", 32'(gg4), 32'd0);
        a4 = 4'b0001; b4 = 4'b0001;
        tick();
        check_value("grp2_p", 32'(gp4), 32'd0);
        check_value("grp2_g", 32'(gg4), 32'd0);
        a4 = 4'b0111; b4 = 4'b1001;
        tick();
        check_value("grp3_g", 32'(gg4), 32'd1);
        v4 = 1'b0;
`endif

        // Random WIDTH=8 traffic with gaps; the model holds the last accepted result
        h8s = 32'(s8); h8g = 32'(g8); h8p = 32'(p8);
        h4s = 32'(s4); h4g = 32'(g4); h4p = 32'(p4);
        for (int k = 0; k < 1000; k++) begin
            ev8 = ($urandom_range(3, 0) != 0);
            v8 = ev8;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            if (ev8) pfa_model(8, 32'(a8), 32'(b8), 32'(c8), h8s, h8g, h8p);
            v4 = 1'b1;
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
            pfa_model(4, 32'(a4), 32'(b4), 32'(c4), h4s, h4g, h4p);
            group_model(4, 32'(a4), 32'(b4), egg, egp);
            tick();
            check_value("rnd_ov", 32'(ov8), 32'(ev8));
            check_value("rnd_sum", 32'(s8), h8s);
            check_value("rnd_g", 32'(g8), h8g);
            check_value("rnd_p", 32'(p8), h8p);
            if (ev8) begin
                logic [31:0] cout;
                check_value("rnd_gp_excl", 32'(g8 & p8), 32'd0);
                cout = 32'd0;
                for (int i = 0; i < 8; i++) begin
                    cout[i] = (int'(a8[i]) + int'(b8[i]) + int'(c8[i])) >= 2;
                end
                check_value("rnd_cout", 32'(g8 | (p8 & c8)), cout);
            end
            check_value("rnd4_sum", 32'(s4), h4s);
`ifdef PFA_GROUP_PG_EN
            check_value("rnd4_grp_g", 32'(gg4), 32'(egg));
            check_value("rnd4_grp_p", 32'(gp4), 32'(egp));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
